// File: rtl/ttt_move_controller_if.sv
// Bundle of move handshake, game_state_memory ports and renderer read-port sharing
// for the tic-tac-toe move controller.
interface ttt_move_controller_if;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_cell;
  logic       move_ready;
  logic       move_ack;
  logic       move_err;
  logic       mem_we;
  logic [3:0] mem_w_addr;
  logic [1:0] mem_data_in;
  logic [3:0] mem_r_addr;
  logic [1:0] mem_data_out;
  logic       vga_req;
  logic [3:0] vga_addr;
  logic       vga_gnt;
  logic [1:0] vga_data;
  logic [1:0] turn;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output new_game, move_valid, move_cell, mem_data_out, vga_req, vga_addr,
    input  move_ready, move_ack, move_err, mem_we, mem_w_addr, mem_data_in,
           mem_r_addr, vga_gnt, vga_data, turn, game_over, winner
  );

  modport slave (
    input  new_game, move_valid, move_cell, mem_data_out, vga_req, vga_addr,
    output move_ready, move_ack, move_err, mem_we, mem_w_addr, mem_data_in,
           mem_r_addr, vga_gnt, vga_data, turn, game_over, winner
  );
endinterface

// File: rtl/ttt_move_controller.sv
// Clears the 3x3 board, validates/commits moves, rescans for win or draw,
// and shares the memory read port with the VGA renderer.
module ttt_move_controller #(
  parameter int unsigned NCELLS = 9,
  parameter int unsigned CW     = 2
) (
  input logic            clk,
  input logic            rst,
  ttt_move_controller_if.slave bus
);
  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD, S_CHK, S_WR, S_SCAN, S_EVAL, S_ERR, S_OVER
  } state_t;

  localparam logic [3:0]    LAST  = 4'(NCELLS - 1);
  localparam logic [3:0]    DRAIN = 4'(NCELLS);
  localparam logic [CW-1:0] EMPTY = '0;
  localparam logic [CW-1:0] P1    = CW'(1);
  localparam logic [CW-1:0] P2    = CW'(2);
  // Each entry packs the three cell indices of one line as hex nibbles.
  localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                        12'h147, 12'h258, 12'h048, 12'h246};

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [3:0]    r_cell;
  logic [CW-1:0] r_turn;
  logic [CW-1:0] r_winner;
  logic          r_game_over;
  logic [CW-1:0] r_board [NCELLS];

  logic          w_win;
  logic [CW-1:0] w_win_code;
  logic          w_full;
  logic [CW-1:0] w_a, w_b, w_c;
  logic          w_ctrl_rd;

  always_comb begin
    w_win      = 1'b0;
    w_win_code = EMPTY;
    w_full     = 1'b1;
    w_a        = EMPTY;
    w_b        = EMPTY;
    w_c        = EMPTY;
    for (int unsigned i = 0; i < NCELLS; i++)
      if (r_board[i[3:0]] == EMPTY) w_full = 1'b0;
    for (int unsigned l = 0; l < 8; l++) begin
      w_a = r_board[LINES[l[2:0]][11:8]];
      w_b = r_board[LINES[l[2:0]][7:4]];
      w_c = r_board[LINES[l[2:0]][3:0]];
      if (!w_win && (w_a == P1 || w_a == P2) && w_a == w_b && w_a == w_c) begin
        w_win      = 1'b1;
        w_win_code = w_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_cell      <= '0;
      r_turn      <= P1;
      r_game_over <= 1'b0;
      r_winner    <= EMPTY;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_turn      <= P1;
          r_game_over <= 1'b0;
          r_winner    <= EMPTY;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (bus.new_game) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_turn      <= P1;
            r_game_over <= 1'b0;
            r_winner    <= EMPTY;
          end else if (bus.move_valid) begin
            if (bus.move_cell > LAST) begin
              r_state <= S_ERR;
            end else begin
              r_cell  <= bus.move_cell;
              r_state <= S_RD;
            end
          end
        end
        S_RD:  r_state <= S_CHK;
        S_CHK: r_state <= (bus.mem_data_out == EMPTY) ? S_WR : S_ERR;
        S_WR: begin
          r_cnt   <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          // Read data trails the address by one cycle, hence the drain step.
          if (r_cnt != '0) r_board[r_cnt - 4'd1] <= bus.mem_data_out;
          if (r_cnt == DRAIN) begin
            r_cnt   <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_EVAL: begin
          if (w_win) begin
            r_game_over <= 1'b1;
            r_winner    <= w_win_code;
            r_state     <= S_OVER;
          end else if (w_full) begin
            r_game_over <= 1'b1;
            r_winner    <= EMPTY;
            r_state     <= S_OVER;
          end else begin
            r_turn  <= (r_turn == P1) ? P2 : P1;
            r_state <= S_IDLE;
          end
        end
        S_ERR: r_state <= S_IDLE;
        S_OVER: begin
          if (bus.new_game) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_turn      <= P1;
            r_game_over <= 1'b0;
            r_winner    <= EMPTY;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign w_ctrl_rd = (r_state == S_RD) || (r_state == S_SCAN);

  // Outputs are masked by rst so the reset cycle never writes or pulses.
  assign bus.move_ready  = rst && (r_state == S_IDLE) && !bus.new_game;
  assign bus.move_ack    = rst && (r_state == S_EVAL);
  assign bus.move_err    = rst && (r_state == S_ERR);
  assign bus.mem_we      = rst && ((r_state == S_CLEAR) || (r_state == S_WR));
  assign bus.mem_w_addr  = (r_state == S_CLEAR) ? r_cnt :
                           (r_state == S_WR)    ? r_cell : '0;
  assign bus.mem_data_in = (r_state == S_WR) ? r_turn : EMPTY;
  assign bus.mem_r_addr  = (r_state == S_RD)   ? r_cell :
                           (r_state == S_SCAN) ? ((r_cnt <= LAST) ? r_cnt : '0) :
                           bus.vga_req         ? bus.vga_addr : '0;
  assign bus.vga_gnt     = bus.vga_req && !w_ctrl_rd;
  assign bus.vga_data    = bus.mem_data_out;
  assign bus.turn        = rst ? r_turn : P1;
  assign bus.game_over   = rst && r_game_over;
  assign bus.winner      = rst ? r_winner : EMPTY;
endmodule

// File: tb/tb_ttt_move_controller.sv
// Scoreboard bench for ttt_move_controller with a behavioural game_state_memory.
module tb_ttt_move_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ttt_move_controller_if bus ();
  ttt_move_controller #(.NCELLS(9), .CW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] mem [9] = '{default: 2'b11};
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_w_addr < 4'd9) mem[bus.mem_w_addr] <= bus.mem_data_in;
    bus.mem_data_out <= (bus.mem_r_addr < 4'd9) ? mem[bus.mem_r_addr] : 2'b00;
  end

  int cyc = 0;
  int wcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_we) wcnt <= wcnt + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct { bit is_err; int lat; } exp_t;
  exp_t sbq [$];

  logic [1:0] m_board [9];
  logic [1:0] m_turn, m_win;
  bit         m_over;
  int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  int hs_cyc = -100;
  int hs_kind = 2;

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
    m_turn = 2'b01; m_over = 0; m_win = 2'b00;
  endtask

  task automatic model_eval();
    bit full;
    logic [1:0] w;
    full = 1; w = 2'b00;
    for (int i = 0; i < 9; i++) if (m_board[i] == 2'b00) full = 0;
    for (int l = 0; l < 8; l++)
      if ((m_board[LN[l][0]] == 2'b01 || m_board[LN[l][0]] == 2'b10) &&
          m_board[LN[l][0]] == m_board[LN[l][1]] && m_board[LN[l][0]] == m_board[LN[l][2]])
        w = m_board[LN[l][0]];
    if (w != 2'b00) begin m_over = 1; m_win = w; end
    else if (full) begin m_over = 1; m_win = 2'b00; end
    else m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
  endtask

  // Monitor: every ack/err pulse pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.move_ack || bus.move_err)) begin
      if (sbq.size() == 0) check("unexpected_pulse", 32'({bus.move_ack, bus.move_err}), 32'd0);
      else begin
        e = sbq.pop_front();
        check("pulse_is_err", 32'(bus.move_err), 32'(e.is_err));
        check("pulse_latency", 32'(cyc - hs_cyc + 1), 32'(e.lat));
      end
    end
  end

  bit vga_chk = 0;
  bit prev_gnt = 0;
  int rel;
  bit busy;
  always @(negedge clk) begin
    if (vga_chk) begin
      rel  = cyc - hs_cyc + 1;
      busy = ((hs_kind != 2) && rel == 1) || (hs_kind == 0 && rel >= 4 && rel <= 13);
      check("vga_gnt", 32'(bus.vga_gnt), 32'(!busy));
      if (prev_gnt) check("vga_data", 32'(bus.vga_data), 32'(m_board[7]));
      prev_gnt = bus.vga_gnt;
    end else prev_gnt = 0;
  end

  task automatic start_move(input logic [3:0] c);
    int k;
    exp_t e;
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_cell  = c;
    #1;
    k = 0;
    while (!bus.move_ready && k < 50) begin @(negedge clk); #1; k++; end
    check("ready_before_move", 32'(bus.move_ready), 32'd1);
    hs_cyc = cyc + 1;
    if (c > 4'd8) begin e.is_err = 1; e.lat = 1; hs_kind = 2; end
    else if (m_board[c] != 2'b00) begin e.is_err = 1; e.lat = 3; hs_kind = 1; end
    else begin
      m_board[c] = m_turn; e.is_err = 0; e.lat = 14; hs_kind = 0;
      model_eval();
    end
    sbq.push_back(e);
    @(negedge clk);
    bus.move_valid = 1'b0;
  endtask

  task automatic do_move(input logic [3:0] c);
    int k, w0;
    w0 = wcnt;
    start_move(c);
    #2;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin @(negedge clk); #2; k++; end
    check("move_done", 32'(sbq.size()), 32'd0);
    sbq.delete();
    @(negedge clk); #1;
    check("turn", 32'(bus.turn), 32'(m_turn));
    check("game_over", 32'(bus.game_over), 32'(m_over));
    check("winner", 32'(bus.winner), 32'(m_win));
    check("move_ready", 32'(bus.move_ready), 32'(!m_over));
    if (c < 4'd9) check("mem_cell", 32'(mem[c]), 32'(m_board[c]));
    check("write_count", 32'(wcnt - w0), (hs_kind == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.move_ready && k < 30) begin @(negedge clk); #1; k++; end
    check("ready_after_clear", 32'(bus.move_ready), 32'd1);
  endtask

  task automatic new_game_seq();
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0; #1;
    check("ng_turn", 32'(bus.turn), 32'd1);
    check("ng_game_over", 32'(bus.game_over), 32'd0);
    check("ng_we", 32'(bus.mem_we), 32'd1);
    check("ng_waddr", 32'(bus.mem_w_addr), 32'd0);
    wait_ready();
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.new_game = 0; bus.move_valid = 0; bus.move_cell = '0;
    bus.vga_req = 0; bus.vga_addr = '0;
    model_reset();

    // 1: reset then clear sweep
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_turn", 32'(bus.turn), 32'd1);
    check("rst_game_over", 32'(bus.game_over), 32'd0);
    check("rst_winner", 32'(bus.winner), 32'd0);
    check("rst_ack", 32'(bus.move_ack), 32'd0);
    check("rst_err", 32'(bus.move_err), 32'd0);
    rst = 1'b1; #1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("clr_we", 32'(bus.mem_we), 32'd1);
      check("clr_addr", 32'(bus.mem_w_addr), 32'(i));
      check("clr_data", 32'(bus.mem_data_in), 32'd0);
    end
    @(negedge clk); #1;
    check("clr_ready", 32'(bus.move_ready), 32'd1);
    check("clr_turn", 32'(bus.turn), 32'd1);
    check("clr_we_off", 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < 9; i++) check("clr_mem", 32'(mem[i]), 32'd0);

    // 2: legal move then repeat onto an occupied cell
    do_move(4'd4);
    do_move(4'd4);

    // 3: out-of-range cell with the renderer reading throughout
    @(negedge clk); bus.vga_req = 1'b1; bus.vga_addr = 4'd7; vga_chk = 1;
    do_move(4'd9);
    vga_chk = 0; bus.vga_req = 1'b0;

    // 4: player1 wins on the top row; further moves ignored
    new_game_seq();
    do_move(4'd0); do_move(4'd3); do_move(4'd1); do_move(4'd4); do_move(4'd2);
    w0 = wcnt;
    @(negedge clk); bus.move_valid = 1'b1; bus.move_cell = 4'd5;
    repeat (5) begin @(negedge clk); #1; end
    check("over_ready", 32'(bus.move_ready), 32'd0);
    bus.move_valid = 1'b0;
    check("over_game_over", 32'(bus.game_over), 32'd1);
    check("over_winner", 32'(bus.winner), 32'd1);
    check("over_no_write", 32'(wcnt - w0), 32'd0);

    // 5: full board without a line is a draw
    new_game_seq();
    do_move(4'd0); do_move(4'd1); do_move(4'd2); do_move(4'd4); do_move(4'd3);
    do_move(4'd5); do_move(4'd7); do_move(4'd6); do_move(4'd8);
    new_game_seq();

    // 6: renderer arbitration during a move, then reset mid-scan
    do_move(4'd7);
    @(negedge clk); bus.vga_req = 1'b1; bus.vga_addr = 4'd7; vga_chk = 1;
    do_move(4'd0);
    repeat (2) @(negedge clk);
    vga_chk = 0; bus.vga_req = 1'b0;
    start_move(4'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0; #1;
    check("midrst_we", 32'(bus.mem_we), 32'd0);
    check("midrst_ack", 32'(bus.move_ack), 32'd0);
    sbq.delete();
    @(negedge clk); rst = 1'b1; #1;
    check("midrst_clear_we", 32'(bus.mem_we), 32'd1);
    check("midrst_clear_addr", 32'(bus.mem_w_addr), 32'd0);
    check("midrst_turn", 32'(bus.turn), 32'd1);
    check("midrst_game_over", 32'(bus.game_over), 32'd0);
    wait_ready();
    model_reset();
    for (int i = 0; i < 9; i++) check("midrst_mem", 32'(mem[i]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
